// File: rtl/fft_pingpong_buffer.sv
// fft_pingpong_buffer
//
// Double-buffered complex sample store placed in front of the FFT butterfly
// pipeline. Frames of N = 2^LOG2N samples are written in natural order into
// one bank while the other bank is replayed, in natural or bit-reversed
// order, on a valid/ready output.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   clear      synchronous soft reset (same effect as RST)
//   in_valid   input sample valid
//   in_ready   buffer can accept a sample this cycle
//   in_re      input real part
//   in_im      input imaginary part
//   bitrev_en  read order for the next frame (1 = bit-reversed), sampled at frame start
//   out_valid  output sample valid
//   out_ready  downstream accepts the output this cycle
//   out_re     output real part
//   out_im     output imaginary part
//   out_index  natural-order address of the current output sample
//   out_last   current output is the final sample of its frame
//   frames_out count of fully drained frames, wraps at 2^16
module fft_pingpong_buffer #(
    parameter int DATA_W         = 16,
    parameter int LOG2N          = 3,
    parameter bit BITREV_DEFAULT = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     bitrev_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic [15:0]              frames_out
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] PTR_LAST = LOG2N'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } rd_state_t;

    function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Both banks live in one array: the bank select is the address MSB.
    logic [2*DATA_W-1:0] mem_q [2*N];

    rd_state_t                 state_q,      state_d;
    logic                      wr_bank_q,    wr_bank_d;
    logic [LOG2N-1:0]          wr_ptr_q,     wr_ptr_d;
    logic                      rd_bank_q,    rd_bank_d;
    logic [LOG2N-1:0]          rd_ptr_q,     rd_ptr_d;
    logic [1:0]                full_q,       full_d;
    logic                      order_q,      order_d;
    logic                      out_valid_q,  out_valid_d;
    logic signed [DATA_W-1:0]  out_re_q,     out_re_d;
    logic signed [DATA_W-1:0]  out_im_q,     out_im_d;
    logic [LOG2N-1:0]          out_index_q,  out_index_d;
    logic                      out_last_q,   out_last_d;
    logic [15:0]               frames_out_q, frames_out_d;

    logic                      wr_fire;
    logic [LOG2N-1:0]          ld_ptr;
    logic                      ld_order;
    logic [LOG2N-1:0]          ld_addr;
    logic [2*DATA_W-1:0]       ld_data;

    assign in_ready   = !full_q[wr_bank_q];
    assign wr_fire    = in_valid && in_ready;

    assign out_valid  = out_valid_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign frames_out = frames_out_q;

    // Address of the sample the output registers load next: the first sample
    // of a frame when leaving IDLE (using the order about to be latched),
    // otherwise the successor of the sample currently presented.
    always_comb begin
        if (state_q == S_IDLE) begin
            ld_ptr   = '0;
            ld_order = bitrev_en;
        end else begin
            ld_ptr   = rd_ptr_q + 1'b1;
            ld_order = order_q;
        end
        ld_addr = ld_order ? bit_reverse(ld_ptr) : ld_ptr;
        ld_data = mem_q[{rd_bank_q, ld_addr}];
    end

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        rd_bank_d    = rd_bank_q;
        rd_ptr_d     = rd_ptr_q;
        full_d       = full_q;
        order_d      = order_q;
        out_valid_d  = out_valid_q;
        out_re_d     = out_re_q;
        out_im_d     = out_im_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        frames_out_d = frames_out_q;

        // Writer. The bank it fills is never the one being drained, so the
        // set below and the clear in the reader touch different full bits.
        if (wr_fire) begin
            if (wr_ptr_q == PTR_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_ptr_d          = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        // Reader
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    order_d     = bitrev_en;
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b1;
                    out_re_d    = ld_data[2*DATA_W-1:DATA_W];
                    out_im_d    = ld_data[DATA_W-1:0];
                    out_index_d = ld_addr;
                    out_last_d  = (ld_ptr == PTR_LAST);
                    state_d     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d       = 1'b0;
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        frames_out_d      = frames_out_q + 16'd1;
                        state_d           = S_IDLE;
                    end else begin
                        rd_ptr_d    = ld_ptr;
                        out_re_d    = ld_data[2*DATA_W-1:DATA_W];
                        out_im_d    = ld_data[DATA_W-1:0];
                        out_index_d = ld_addr;
                        out_last_d  = (ld_ptr == PTR_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Soft reset wins over everything above; partial frames are dropped.
        if (clear) begin
            state_d      = S_IDLE;
            wr_bank_d    = 1'b0;
            wr_ptr_d     = '0;
            rd_bank_d    = 1'b0;
            rd_ptr_d     = '0;
            full_d       = 2'b00;
            order_d      = BITREV_DEFAULT;
            out_valid_d  = 1'b0;
            out_re_d     = '0;
            out_im_d     = '0;
            out_index_d  = '0;
            out_last_d   = 1'b0;
            frames_out_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_ptr_q     <= '0;
            full_q       <= 2'b00;
            order_q      <= BITREV_DEFAULT;
            out_valid_q  <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            frames_out_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_bank_q    <= rd_bank_d;
            rd_ptr_q     <= rd_ptr_d;
            full_q       <= full_d;
            order_q      <= order_d;
            out_valid_q  <= out_valid_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            frames_out_q <= frames_out_d;
        end
    end

    // Sample storage carries no reset; stale contents are never read because
    // the full flags gate the reader.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem_q[{wr_bank_q, wr_ptr_q}] <= {in_re, in_im};
        end
    end

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
module tb_fft_pingpong_buffer;

    localparam int LG = 3;
    localparam int N  = 1 << LG;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic        bitrev_en = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [2:0]  out_index;
    logic        out_last;
    logic [15:0] frames_out;

    fft_pingpong_buffer #(
        .DATA_W(16),
        .LOG2N(LG),
        .BITREV_DEFAULT(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_re(in_re),
        .in_im(in_im),
        .bitrev_en(bitrev_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re(out_re),
        .out_im(out_im),
        .out_index(out_index),
        .out_last(out_last),
        .frames_out(frames_out)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    // Reference model: completed frames become a queue of expected beats.
    exp_t        exp_q[$];
    logic [15:0] wbuf_re[N];
    logic [15:0] wbuf_im[N];
    int          wcnt, held, drained, acc_cnt, fire_cnt;
    bit          expect_idle, expect_rise;
    bit          brev, rand_data;
    logic [15:0] src_re, src_im;
    bit          prev_hold;
    logic [15:0] hold_re, hold_im;
    logic [2:0]  hold_idx;
    logic [15:0] f0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < LG; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    task automatic push_frame();
        exp_t e;
        int a;
        for (int k = 0; k < N; k++) begin
            a      = brev ? rev(k) : k;
            e.re   = wbuf_re[a];
            e.im   = wbuf_im[a];
            e.idx  = 3'(a);
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        wcnt = 0; held = 0; drained = 0;
        expect_idle = 0; expect_rise = 0; prev_hold = 0;
    endtask

    task automatic next_src();
        if (rand_data) src_re = 16'($urandom);
        else           src_re = src_re + 16'd1;
        src_im = 16'($urandom);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'(1));
        chk({tag, "_out_valid"},  32'(out_valid),  32'(0));
        chk({tag, "_out_re"},     32'(out_re),     32'(0));
        chk({tag, "_out_im"},     32'(out_im),     32'(0));
        chk({tag, "_out_index"},  32'(out_index),  32'(0));
        chk({tag, "_out_last"},   32'(out_last),   32'(0));
        chk({tag, "_frames_out"}, 32'(frames_out), 32'(0));
    endtask

    // One clock cycle: drive inputs, check the registered outputs against the
    // model, account for handshakes, then advance to just after the edge.
    task automatic tick(input bit v, input bit r);
        exp_t e;
        in_valid  = v;
        out_ready = r;
        in_re     = src_re;
        in_im     = src_im;
        bitrev_en = brev;

        chk("in_ready",   32'(in_ready),   32'(held < 2));
        chk("frames_out", 32'(frames_out), 32'(16'(drained)));

        if (expect_idle) begin
            chk("gap_idle", 32'(out_valid), 32'(0));
            expect_idle = 0;
            expect_rise = (exp_q.size() > 0);
        end else if (expect_rise) begin
            chk("gap_rise", 32'(out_valid), 32'(1));
            expect_rise = 0;
        end

        if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_re",    32'(out_re),    32'(hold_re));
            chk("hold_im",    32'(out_im),    32'(hold_im));
            chk("hold_index", 32'(out_index), 32'(hold_idx));
        end

        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'(0));
            end else begin
                e = exp_q[0];
                chk("out_re",    32'(out_re),    32'(e.re));
                chk("out_im",    32'(out_im),    32'(e.im));
                chk("out_index", 32'(out_index), 32'(e.idx));
                chk("out_last",  32'(out_last),  32'(e.last));
                if (r) begin
                    void'(exp_q.pop_front());
                    fire_cnt++;
                    if (e.last) begin
                        drained++;
                        held--;
                        expect_idle = 1;
                    end
                end
            end
        end

        prev_hold = (out_valid === 1'b1) && !r;
        hold_re   = out_re;
        hold_im   = out_im;
        hold_idx  = out_index;

        if (v && in_ready === 1'b1) begin
            wbuf_re[wcnt] = src_re;
            wbuf_im[wcnt] = src_im;
            wcnt++;
            acc_cnt++;
            if (wcnt == N) begin
                push_frame();
                held++;
                wcnt = 0;
            end
            next_src();
        end

        @(posedge CLK);
        #1;
    endtask

    initial begin
        model_reset();
        fire_cnt = 0; acc_cnt = 0;
        brev = 1; rand_data = 0;
        src_re = 16'd0; src_im = 16'd0;

        // Reset
        repeat (3) @(posedge CLK);
        #3 RST = 1'b1;
        @(posedge CLK);
        #1;
        check_reset("rst");

        // Bit-reversed frame 0..7, first-output latency
        brev = 1; rand_data = 0; src_re = 16'd0; src_im = 16'($urandom); acc_cnt = 0;
        for (int i = 0; i < 50 && acc_cnt < N; i++) tick(1, 1);
        chk("t1_accepts", 32'(acc_cnt), 32'(N));
        chk("t1_lat_idle", 32'(out_valid), 32'(0));
        tick(0, 1);
        chk("t1_lat_rise", 32'(out_valid), 32'(1));
        chk("t1_first_re", 32'(out_re), 32'(0));
        repeat (12) tick(0, 1);
        chk("t1_frames_out", 32'(frames_out), 32'(1));
        chk("t1_drained", 32'(exp_q.size()), 32'(0));

        // Natural-order frame
        brev = 0; src_re = 16'd0; acc_cnt = 0;
        for (int i = 0; i < 50 && acc_cnt < N; i++) tick(1, 1);
        chk("t2_accepts", 32'(acc_cnt), 32'(N));
        repeat (14) tick(0, 1);
        chk("t2_frames_out", 32'(frames_out), 32'(2));
        chk("t2_drained", 32'(exp_q.size()), 32'(0));

        // Both banks full with downstream stalled
        brev = 1; src_re = 16'd0; acc_cnt = 0;
        repeat (30) tick(1, 0);
        chk("t3_stall_accepts", 32'(acc_cnt), 32'(16));
        chk("t3_stall_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < 100 && acc_cnt < 24; i++) tick(1, 1);
        chk("t3_accepts", 32'(acc_cnt), 32'(24));
        repeat (40) tick(0, 1);
        chk("t3_drained", 32'(exp_q.size()), 32'(0));

        // Continuous 4-frame stream, random data
        rand_data = 1; brev = 1'($urandom); next_src(); acc_cnt = 0;
        f0 = frames_out;
        for (int i = 0; i < 200 && acc_cnt < 4 * N; i++) tick(1, 1);
        chk("t4_accepts", 32'(acc_cnt), 32'(4 * N));
        repeat (30) tick(0, 1);
        chk("t4_frames", 32'(16'(frames_out - f0)), 32'(4));
        chk("t4_drained", 32'(exp_q.size()), 32'(0));

        // Random in_valid / out_ready
        brev = 1'($urandom);
        for (int i = 0; i < 400; i++) tick(1'($urandom), 1'($urandom));
        for (int i = 0; i < 100 && wcnt != 0; i++) tick(1, 1'($urandom));
        repeat (40) tick(0, 1);
        chk("t5_partial", 32'(wcnt), 32'(0));
        chk("t5_drained", 32'(exp_q.size()), 32'(0));

        // Asynchronous reset while frame 0 drains and frame 1 is partial
        brev = 1; rand_data = 0; src_re = 16'h0100; acc_cnt = 0;
        for (int i = 0; i < 100 && acc_cnt < N; i++) tick(1, 0);
        for (int i = 0; i < 100 && acc_cnt < N + 5; i++) tick(1, 1'($urandom));
        chk("t6_accepts", 32'(acc_cnt), 32'(N + 5));
        in_valid = 1'b0; out_ready = 1'b0;
        #2 RST = 1'b0;
        #1;
        check_reset("t6_async");
        model_reset();
        @(posedge CLK);
        #3 RST = 1'b1;
        @(posedge CLK);
        #1;
        check_reset("t6_release");
        src_re = 16'h0200; acc_cnt = 0; fire_cnt = 0;
        for (int i = 0; i < 50 && acc_cnt < N; i++) tick(1, 1);
        repeat (20) tick(0, 1);
        chk("t6_beats", 32'(fire_cnt), 32'(N));
        chk("t6_frames_out", 32'(frames_out), 32'(1));

        // Synchronous clear while a frame is presented and another is partial
        brev = 0; src_re = 16'h0300; acc_cnt = 0;
        for (int i = 0; i < 50 && acc_cnt < N + 3; i++) tick(1, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        clear = 1'b1;
        @(posedge CLK);
        #1;
        clear = 1'b0;
        model_reset();
        check_reset("t7_clear");
        src_re = 16'h0400; acc_cnt = 0; fire_cnt = 0;
        for (int i = 0; i < 50 && acc_cnt < N; i++) tick(1, 1);
        repeat (20) tick(0, 1);
        chk("t7_beats", 32'(fire_cnt), 32'(N));
        chk("t7_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
